lut_scan_ctrl: RTL and testbench

LUT_SCAN_CTRL -- requirements
Module: lut_scan_ctrl

---
 rtl/lut_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_lut_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_scan_ctrl.sv
// rtl/lut_scan_ctrl.sv - credit-based LUT address scanner with elastic output buffer
// Optional checksum output enabled by defining LUT_SCAN_CKSUM_EN.
module lut_scan_ctrl #(
    parameter int LUT_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  start_addr,
    input  logic [7:0]  step,
    input  logic [8:0]  count,
    output logic [7:0]  lut_a,
    input  logic [7:0]  lut_q,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
`ifdef LUT_SCAN_CKSUM_EN
    ,
    output logic [15:0] cksum
`endif
);

    localparam int DEPTH = LUT_LATENCY + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [1:0]             rst_sync;
    logic [7:0]             step_r;
    logic [8:0]             remaining;
    logic [LUT_LATENCY-1:0] inflight;
    logic [7:0]             fifo [4];
    logic [1:0]             occ;
    logic [2:0]             infl_cnt;
    logic [2:0]             used;
    logic                   start_acc;
    logic                   issue;
    logic                   pop;
    logic                   wr;
    logic                   drained;

    assign out_valid = (occ != 2'd0);
    assign out_data  = fifo[0];

    // A handshake in this cycle frees a slot, so it may be reused by this cycle's read.
    always_comb begin
        infl_cnt = 3'd0;
        for (int i = 0; i < LUT_LATENCY; i++) begin
            infl_cnt = infl_cnt + {2'b00, inflight[i]};
        end
        pop       = out_valid & out_ready;
        wr        = inflight[LUT_LATENCY-1];
        used      = infl_cnt + {1'b0, occ} - {2'b00, pop};
        start_acc = (state == IDLE) && start && rst_sync[1];
        issue     = (state == RUN) && (used < 3'(DEPTH));
        drained   = (infl_cnt == 3'd0) && (occ == {1'b0, pop});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rst_sync  <= 2'b00;
            lut_a     <= 8'h00;
            step_r    <= 8'h00;
            remaining <= 9'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        lut_a     <= start_addr;
                        step_r    <= step;
                        remaining <= count;
                        busy      <= 1'b1;
                        if (count == 9'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        lut_a     <= lut_a + step_r;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift FIFO with the head at entry 0; the write index accounts for a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            occ      <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                fifo[i] <= 8'h00;
            end
        end else begin
            inflight <= LUT_LATENCY'({inflight, issue});
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    fifo[i] <= fifo[i+1];
                end
            end
            if (wr) begin
                fifo[occ - {1'b0, pop}] <= lut_q;
            end
            occ <= occ + {1'b0, wr} - {1'b0, pop};
        end
    end

`ifdef LUT_SCAN_CKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum <= 16'h0000;
        end else if (start_acc) begin
            cksum <= 16'h0000;
        end else if (pop) begin
            cksum <= cksum + {8'h00, out_data};
        end
    end
`endif

endmodule

// File: tb/tb_lut_scan_ctrl.sv
// tb/tb_lut_scan_ctrl.sv - bench for lut_scan_ctrl at LUT_LATENCY 1 and 2 side by side
module tb_lut_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] start_addr = 8'h00;
    logic [7:0] step = 8'h00;
    logic [8:0] count = 9'd0;
    logic       out_ready = 1'b1;

    logic [7:0] lut1_a, lut2_a;
    logic [7:0] lut1_q = 8'h00;
    logic [7:0] lut2_s = 8'h00;
    logic [7:0] lut2_q = 8'h00;
    logic [7:0] od1, od2;
    logic       ov1, ov2, bs1, bs2, dn1, dn2;
`ifdef LUT_SCAN_CKSUM_EN
    logic [15:0] ck1, ck2;
    logic [15:0] sum_m [2];
`endif

    always #5 clk = ~clk;

    lut_scan_ctrl #(.LUT_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .step(step), .count(count), .lut_a(lut1_a), .lut_q(lut1_q),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .busy(bs1), .done(dn1)
`ifdef LUT_SCAN_CKSUM_EN
        , .cksum(ck1)
`endif
    );

    lut_scan_ctrl #(.LUT_LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .step(step), .count(count), .lut_a(lut2_a), .lut_q(lut2_q),
        .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
        .busy(bs2), .done(dn2)
`ifdef LUT_SCAN_CKSUM_EN
        , .cksum(ck2)
`endif
    );

    // LUT contents: data = addr ^ A5, one or two register stages
    always @(posedge clk) begin
        lut1_q <= lut1_a ^ 8'hA5;
        lut2_s <= lut2_a ^ 8'hA5;
        lut2_q <= lut2_s;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] expd [2][512];
    logic [7:0] rec  [2][512];
    int         head [2];
    int         tail [2];
    int         nrec [2];
    int         start_cyc [2];
    int         first_valid [2];
    bit         done_due [2];
    bit         exp_busy [2];
    bit         prev_stall [2];
    logic [7:0] prev_d [2];
    int         cyc = 0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            head[k] = 0; tail[k] = 0; nrec[k] = 0; start_cyc[k] = 0; first_valid[k] = -1;
            done_due[k] = 0; exp_busy[k] = 0; prev_stall[k] = 0; prev_d[k] = 8'h00;
`ifdef LUT_SCAN_CKSUM_EN
            sum_m[k] = 16'h0000;
`endif
        end
    end

    // Reference behaviour: every accepted start enqueues the full expected sample list;
    // each handshake must pop its head; done follows the handshake that empties it.
    always @(negedge clk) begin : cmp
        logic       v, dn, bs;
        logic [7:0] d;
        bit         nd, nb;
        logic [7:0] a;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            v  = (k == 0) ? ov1 : ov2;
            d  = (k == 0) ? od1 : od2;
            dn = (k == 0) ? dn1 : dn2;
            bs = (k == 0) ? bs1 : bs2;
            if (!rst_n) begin
                chk(v == 1'b0, $sformatf("rst_valid%0d", k), int'(v), 0);
                chk(dn == 1'b0, $sformatf("rst_done%0d", k), int'(dn), 0);
                chk(bs == 1'b0, $sformatf("rst_busy%0d", k), int'(bs), 0);
`ifdef LUT_SCAN_CKSUM_EN
                chk(((k == 0) ? ck1 : ck2) == 16'h0, $sformatf("rst_cksum%0d", k),
                    int'((k == 0) ? ck1 : ck2), 0);
                sum_m[k] = 16'h0000;
`endif
                head[k] = 0; tail[k] = 0;
                done_due[k] = 0; exp_busy[k] = 0; prev_stall[k] = 0;
            end else begin
                chk(dn === done_due[k], $sformatf("done%0d", k), int'(dn), int'(done_due[k]));
                chk(bs === exp_busy[k], $sformatf("busy%0d", k), int'(bs), int'(exp_busy[k]));
`ifdef LUT_SCAN_CKSUM_EN
                chk(((k == 0) ? ck1 : ck2) === sum_m[k], $sformatf("cksum%0d", k),
                    int'((k == 0) ? ck1 : ck2), int'(sum_m[k]));
`endif
                nd = 1'b0;
                if (prev_stall[k]) begin
                    chk(v === 1'b1, $sformatf("hold_valid%0d", k), int'(v), 1);
                    chk(d === prev_d[k], $sformatf("hold_data%0d", k), int'(d), int'(prev_d[k]));
                end
                if (v === 1'b1) begin
                    if (first_valid[k] < 0) first_valid[k] = cyc;
                    if (head[k] == tail[k]) begin
                        chk(1'b0 == v, $sformatf("spurious_valid%0d", k), int'(v), 0);
                    end else if (out_ready) begin
                        chk(d === expd[k][head[k]], $sformatf("data%0d", k), int'(d),
                            int'(expd[k][head[k]]));
                        if (nrec[k] < 512) begin
                            rec[k][nrec[k]] = d;
                            nrec[k]++;
                        end
`ifdef LUT_SCAN_CKSUM_EN
                        sum_m[k] = sum_m[k] + {8'h00, d};
`endif
                        head[k]++;
                        if (head[k] == tail[k]) nd = 1'b1;
                    end
                end
                prev_stall[k] = (v === 1'b1) && !out_ready;
                prev_d[k] = d;
                nb = exp_busy[k];
                if (done_due[k]) nb = 1'b0;
                if (start && !exp_busy[k]) begin
                    nb = 1'b1;
                    head[k] = 0; tail[k] = 0; nrec[k] = 0;
                    start_cyc[k] = cyc; first_valid[k] = -1;
`ifdef LUT_SCAN_CKSUM_EN
                    sum_m[k] = 16'h0000;
`endif
                    for (int i = 0; i < int'(count); i++) begin
                        a = 8'((int'(start_addr) + i * int'(step)) & 255);
                        expd[k][tail[k]] = a ^ 8'hA5;
                        tail[k]++;
                    end
                    if (count == 9'd0) nd = 1'b1;
                end
                done_due[k] = nd;
                exp_busy[k] = nb;
            end
        end
    end

    task automatic do_scan(input logic [7:0] sa, input logic [7:0] st, input logic [8:0] cnt,
                           input bit toggle, input bit poke);
        int n;
        start_addr = sa; step = st; count = cnt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while ((bs1 || bs2) && n < 3000) begin
            if (toggle) out_ready = ~out_ready;
            if (poke && n == 5) begin
                start = 1'b1; start_addr = 8'h77; step = 8'h02; count = 9'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk(n < 3000, "scan_timeout", n, 3000);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_rec(input int k, input int idx, input logic [7:0] exp);
        chk(rec[k][idx] === exp, $sformatf("lit%0d_%0d", k, idx), int'(rec[k][idx]), int'(exp));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(lut1_a == 8'h00, "reset_lut_a1", int'(lut1_a), 0);
        chk(lut2_a == 8'h00, "reset_lut_a2", int'(lut2_a), 0);
        chk(od1 == 8'h00, "reset_data1", int'(od1), 0);
        chk(od2 == 8'h00, "reset_data2", int'(od2), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Basic scan
        do_scan(8'h10, 8'h01, 9'd4, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk(nrec[k] == 4, $sformatf("t1_n%0d", k), nrec[k], 4);
            chk_rec(k, 0, 8'hB5); chk_rec(k, 1, 8'hB4);
            chk_rec(k, 2, 8'hB7); chk_rec(k, 3, 8'hB6);
        end
        chk(first_valid[0] - start_cyc[0] - 1 == 2, "latency_l1", first_valid[0] - start_cyc[0] - 1, 2);
        chk(first_valid[1] - start_cyc[1] - 1 == 3, "latency_l2", first_valid[1] - start_cyc[1] - 1, 3);
`ifdef LUT_SCAN_CKSUM_EN
        chk(ck1 == 16'h02D6, "cksum_lit1", int'(ck1), 16'h02D6);
        chk(ck2 == 16'h02D6, "cksum_lit2", int'(ck2), 16'h02D6);
`endif

        // Address wrap
        do_scan(8'hFE, 8'h01, 9'd3, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk(nrec[k] == 3, $sformatf("t2_n%0d", k), nrec[k], 3);
            chk_rec(k, 0, 8'h5B); chk_rec(k, 1, 8'h5A); chk_rec(k, 2, 8'hA5);
        end

        // Backpressure toggling plus an ignored start while busy
        out_ready = 1'b1;
        do_scan(8'h40, 8'h07, 9'd16, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk(nrec[k] == 16, $sformatf("t3_n%0d", k), nrec[k], 16);
            chk_rec(k, 0, 8'h40 ^ 8'hA5); chk_rec(k, 15, 8'(8'h40 + 8'd105) ^ 8'hA5);
        end

        // Empty scan
        do_scan(8'h55, 8'h01, 9'd0, 1'b0, 1'b0);
        chk(nrec[0] == 0, "t4_n0", nrec[0], 0);
        chk(nrec[1] == 0, "t4_n1", nrec[1], 0);

        // Abort a long scan with reset, then run a short one
        start_addr = 8'h30; step = 8'h01; count = 9'd256; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk(lut1_a == 8'h00, "abort_lut_a1", int'(lut1_a), 0);
        chk(lut2_a == 8'h00, "abort_lut_a2", int'(lut2_a), 0);
        chk(ov1 == 1'b0 && ov2 == 1'b0, "abort_valid", int'({ov1, ov2}), 0);
        chk(od1 == 8'h00 && od2 == 8'h00, "abort_data", int'({od1, od2}), 0);
        chk(bs1 == 1'b0 && bs2 == 1'b0, "abort_busy", int'({bs1, bs2}), 0);
        chk(dn1 == 1'b0 && dn2 == 1'b0, "abort_done", int'({dn1, dn2}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        do_scan(8'h20, 8'h03, 9'd2, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk(nrec[k] == 2, $sformatf("t5_n%0d", k), nrec[k], 2);
            chk_rec(k, 0, 8'h85); chk_rec(k, 1, 8'h86);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
